// File: rtl/friscv_sv_pkg.sv
// Core-wide constants and small helpers shared by the friscv pipeline blocks.
package friscv_sv_pkg;

  localparam int ARCH           = 32;
  localparam int IMEM_DEPTH_DEF = 4096;

  // Byte-address width needed to cover a memory of depth words of width bits.
  function automatic int imem_addr_w(input int depth, input int width);
    return $clog2(depth * width / 8);
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_sram_dp.sv
// Simple dual-port RAM: port A is a byte-strobed write port, port B a registered
// read port with read enable. A same-word read and write returns the old contents.
module sram_dp
  import friscv_sv_pkg::*;
#(
  parameter int RAM_WIDTH = ARCH,
  parameter int RAM_DEPTH = IMEM_DEPTH_DEF,
  parameter     INIT_FILE = "",
  localparam int IDX_W    = $clog2(RAM_DEPTH),
  localparam int STRB_W   = RAM_WIDTH / 8
)(
  input  logic                 clk,
  input  logic                 we_a_i,
  input  logic [IDX_W-1:0]     addr_a_i,
  input  logic [STRB_W-1:0]    strb_a_i,
  input  logic [RAM_WIDTH-1:0] din_a_i,
  input  logic                 re_b_i,
  input  logic [IDX_W-1:0]     addr_b_i,
  output logic [RAM_WIDTH-1:0] dout_b_o
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] dout_q;

  // This RAM has no preload path; contents are loaded through the write port.
  if (INIT_FILE != "") begin : g_init_note
    $warning("sram_dp: INIT_FILE is not preloaded; load memory through the write port");
  end

  always_ff @(posedge clk) begin
    if (we_a_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_a_i[b]) begin
          mem[addr_a_i][8*b +: 8] <= din_a_i[8*b +: 8];
        end
      end
    end
  end

  // Non-blocking read alongside the write block gives read-first on collisions.
  always_ff @(posedge clk) begin
    if (re_b_i) begin
      dout_q <= mem[addr_b_i];
    end
  end

  assign dout_b_o = dout_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the pipelined core: stallable/flushable fetch pipeline over a
// dual-port RAM, with an optional output register and a run-time programming port.
module instr_mem_ctrl
  import friscv_sv_pkg::*;
#(
  parameter int RAM_WIDTH = ARCH,
  parameter int RAM_DEPTH = IMEM_DEPTH_DEF,
  parameter     INIT_FILE = "",
  parameter int OUT_REG   = 1,
  localparam int ADDR_W   = imem_addr_w(RAM_DEPTH, RAM_WIDTH)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req_in,
  input  logic [ADDR_W-1:0]      fetch_addr_byte_in,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic [RAM_WIDTH-1:0]   instr_data_out,
  output logic                   instr_valid_out,
  output logic                   instr_misalign_out,
  input  logic                   prog_we_in,
  input  logic [ADDR_W-1:0]      prog_addr_byte_in,
  input  logic [RAM_WIDTH/8-1:0] prog_strb_in,
  input  logic [RAM_WIDTH-1:0]   prog_data_in
);

  localparam int STRB_W = RAM_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFS;

  if ((RAM_WIDTH % 8) != 0 || RAM_WIDTH < 16) begin : g_bad_width
    $error("instr_mem_ctrl: RAM_WIDTH must be a multiple of 8 and at least 16");
  end
  if ((1 << $clog2(RAM_DEPTH)) != RAM_DEPTH) begin : g_bad_depth
    $error("instr_mem_ctrl: RAM_DEPTH must be a power of 2");
  end

  logic [IDX_W-1:0]     fetchIdx;
  logic [IDX_W-1:0]     progIdx;
  logic                 fetchMisalign;
  logic                 unusedProgOffset;
  logic [RAM_WIDTH-1:0] sramDout;

  assign fetchIdx         = fetch_addr_byte_in[ADDR_W-1:OFS];
  assign fetchMisalign    = |fetch_addr_byte_in[OFS-1:0];
  assign progIdx          = prog_addr_byte_in[ADDR_W-1:OFS];
  assign unusedProgOffset = ^prog_addr_byte_in[OFS-1:0];

  sram_dp #(
    .RAM_WIDTH (RAM_WIDTH),
    .RAM_DEPTH (RAM_DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk      (clk),
    .we_a_i   (prog_we_in),
    .addr_a_i (progIdx),
    .strb_a_i (prog_strb_in),
    .din_a_i  (prog_data_in),
    .re_b_i   (~stall_in),
    .addr_b_i (fetchIdx),
    .dout_b_o (sramDout)
  );

  logic v1_q, v1_d;
  logic m1_q, m1_d;

  // Flush beats stall: in-flight fetches die even while the pipeline is held.
  always_comb begin
    v1_d = v1_q;
    m1_d = m1_q;
    if (flush_in) begin
      v1_d = 1'b0;
      m1_d = 1'b0;
    end else if (!stall_in) begin
      v1_d = fetch_req_in;
      m1_d = fetch_req_in & fetchMisalign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      m1_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      m1_q <= m1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [RAM_WIDTH-1:0] data_q, data_d;
    logic                 v2_q, v2_d;
    logic                 m2_q, m2_d;

    always_comb begin
      data_d = data_q;
      v2_d   = v2_q;
      m2_d   = m2_q;
      if (!stall_in) begin
        data_d = sramDout;
        v2_d   = v1_q;
        m2_d   = m1_q;
      end
      if (flush_in) begin
        v2_d = 1'b0;
        m2_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        v2_q   <= 1'b0;
        m2_q   <= 1'b0;
      end else begin
        data_q <= data_d;
        v2_q   <= v2_d;
        m2_q   <= m2_d;
      end
    end

    assign instr_data_out     = m2_q ? '0 : data_q;
    assign instr_valid_out    = v2_q & ~m2_q;
    assign instr_misalign_out = m2_q;
  end else begin : g_no_out_reg
    // Without the register, data is zeroed whenever no good word is presented.
    assign instr_data_out     = (v1_q & ~m1_q) ? sramDout : '0;
    assign instr_valid_out    = v1_q & ~m1_q;
    assign instr_misalign_out = m1_q;
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: both output-register variants share one stimulus
// stream and are compared every cycle against a tick-based reference of the fetch stream.
module tb_instr_mem_ctrl;
  import friscv_sv_pkg::*;

  localparam int W     = ARCH;
  localparam int SW    = W / 8;
  localparam int DEPTH = 64;
  localparam int AW    = imem_addr_w(DEPTH, W);
  localparam int MAXT  = 4096;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          fetchReq  = 1'b0;
  logic [AW-1:0] fetchAddr = '0;
  logic          stall     = 1'b0;
  logic          flush     = 1'b0;
  logic          progWe    = 1'b0;
  logic [AW-1:0] progAddr  = '0;
  logic [SW-1:0] progStrb  = '0;
  logic [W-1:0]  progData  = '0;

  logic [W-1:0]  dataReg, dataComb;
  logic          validReg, validComb, misReg, misComb;

  int compareCount = 0;
  int failCount    = 0;

  // Reference: memory image plus one record per accepted (unstalled) edge, indexed by tick.
  logic [W-1:0] refMem [DEPTH];
  int           tick         = 0;
  int           edgeNum      = 0;
  int           lastKillEdge = -1;
  bit           resetEdge    = 1'b0;
  bit           recReq  [MAXT];
  bit           recMis  [MAXT];
  logic [W-1:0] recData [MAXT];
  int           recEdge [MAXT];

  instr_mem_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .INIT_FILE(""), .OUT_REG(1)) dutReg (
    .clk(clk), .rst(rst), .fetch_req_in(fetchReq), .fetch_addr_byte_in(fetchAddr),
    .stall_in(stall), .flush_in(flush), .instr_data_out(dataReg),
    .instr_valid_out(validReg), .instr_misalign_out(misReg), .prog_we_in(progWe),
    .prog_addr_byte_in(progAddr), .prog_strb_in(progStrb), .prog_data_in(progData)
  );

  instr_mem_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .INIT_FILE(""), .OUT_REG(0)) dutComb (
    .clk(clk), .rst(rst), .fetch_req_in(fetchReq), .fetch_addr_byte_in(fetchAddr),
    .stall_in(stall), .flush_in(flush), .instr_data_out(dataComb),
    .instr_valid_out(validComb), .instr_misalign_out(misComb), .prog_we_in(progWe),
    .prog_addr_byte_in(progAddr), .prog_strb_in(progStrb), .prog_data_in(progData)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (tick %0d)", tag, observed, expected, tick);
    end
  endtask

  // Advance the reference by one clock edge using the inputs that were sampled at it.
  task automatic modelEdge();
    int a;
    int pa;
    edgeNum++;
    if (!stall) begin
      tick++;
      a             = int'(fetchAddr);
      recReq[tick]  = fetchReq;
      recMis[tick]  = (a % SW) != 0;
      recData[tick] = refMem[a / SW];
      recEdge[tick] = edgeNum;
    end
    if (rst || flush) lastKillEdge = edgeNum;
    resetEdge = rst;
    if (progWe) begin
      pa = int'(progAddr) / SW;
      for (int b = 0; b < SW; b++) begin
        if (progStrb[b]) refMem[pa][8*b +: 8] = progData[8*b +: 8];
      end
    end
  endtask

  // A fetch shows up lat-1 unstalled edges after it was taken, unless a flush or reset came since.
  task automatic checkCycle(input int lat, input string name, input logic [W-1:0] data,
                            input logic valid, input logic mis);
    int           t;
    bit           live;
    logic [W-1:0] expData;
    t    = tick - (lat - 1);
    if (t < 0) t = 0;
    live = recReq[t] && (recEdge[t] > lastKillEdge);
    checkOutput({name, ".valid"}, W'(valid), W'(live && !recMis[t]));
    checkOutput({name, ".misalign"}, W'(mis), W'(live && recMis[t]));
    expData = (live && !recMis[t]) ? recData[t] : '0;
    if (live || resetEdge) checkOutput({name, ".data"}, data, expData);
  endtask

  task automatic applyStimulus(input bit req, input int addr, input bit stallIn,
                               input bit flushIn, input bit rstIn, input bit we,
                               input int paddr, input int strb, input logic [W-1:0] pdata);
    fetchReq  = req;
    fetchAddr = AW'(addr);
    stall     = stallIn;
    flush     = flushIn;
    rst       = rstIn;
    progWe    = we;
    progAddr  = AW'(paddr);
    progStrb  = SW'(strb);
    progData  = pdata;
    @(posedge clk);
    modelEdge();
    #1;
    checkCycle(2, "outreg", dataReg, validReg, misReg);
    checkCycle(1, "direct", dataComb, validComb, misComb);
  endtask

  task automatic fetchWord(input int addr);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
  endtask

  initial begin
    repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, '0);

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, i * SW, 'hF, W'($urandom()));

    $display("[TB] back-to-back fetch of preloaded words");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, i * SW, 'hF, W'((i + 1) * 32'h11111111));
    for (int i = 0; i < 4; i++) fetchWord(i * SW);
    idleCycles(3);

    $display("[TB] stall in the middle of a fetch stream");
    fetchWord(0);
    fetchWord(4);
    repeat (3) applyStimulus(1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    fetchWord(8);
    idleCycles(3);

    $display("[TB] flush with fetches in flight");
    fetchWord(0);
    fetchWord(4);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, '0);
    fetchWord(8);
    idleCycles(3);

    $display("[TB] misaligned fetch");
    fetchWord(6);
    idleCycles(3);

    $display("[TB] read/write collision on the same word");
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 20, 'hF, '0);
    applyStimulus(1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b1, 20, 'h5, 32'hAABBCCDD);
    fetchWord(20);
    idleCycles(3);

    $display("[TB] reset with fetches in flight");
    fetchWord(0);
    fetchWord(4);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, '0);
    fetchWord(0);
    fetchWord(4);
    idleCycles(3);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 800; n++) begin
      int  a;
      bit  req, stl, fls, rs, we;
      a = $urandom_range(0, DEPTH - 1) * SW;
      if ($urandom_range(0, 4) == 0) a = a + $urandom_range(1, SW - 1);
      req = $urandom_range(0, 99) < 70;
      stl = $urandom_range(0, 99) < 20;
      fls = $urandom_range(0, 99) < 8;
      rs  = $urandom_range(0, 99) < 3;
      we  = $urandom_range(0, 99) < 30;
      applyStimulus(req, a, stl, fls, rs, we, $urandom_range(0, DEPTH * SW - 1),
                    $urandom_range(0, (1 << SW) - 1), W'($urandom()));
    end
    idleCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
